// File: rtl/nano_mem_responder.sv
// ============================================================================
//  Module   : nano_mem_responder
//  Purpose  : NanoCPU memory responder: loader-fed RAM plus one mapped IO register.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module nano_mem_responder #(
   parameter int              AW      = 8,
   parameter int              DW      = 16,
   parameter int              DEPTH   = 256,
   parameter logic [AW-1:0]   IO_ADDR = 8'hFF
) (
   input  logic          ck,
   input  logic          rst,
   input  logic [AW-1:0] address,
   input  logic [DW-1:0] dataW,
   input  logic          ce,
   input  logic          we,
   output logic [DW-1:0] dataR,
   input  logic          ld_valid,
   input  logic [DW-1:0] ld_data,
   input  logic          ld_last,
   output logic          ld_ready,
   output logic [AW:0]   ld_words,
   output logic          cpu_rst,
   output logic [DW-1:0] io_out,
   output logic          io_strobe,
   output logic [15:0]   wr_count
);

   localparam logic [0:0]  S_LOAD      = 1'b0;
   localparam logic [0:0]  S_RUN       = 1'b1;
   localparam logic [AW:0] C_LAST_WORD = (AW+1)'(DEPTH - 1);

   logic [0:0]    state_q,     state_d;
   logic [AW:0]   ld_words_q,  ld_words_d;
   logic          cpu_rst_q;
   logic [DW-1:0] io_out_q,    io_out_d;
   logic          io_strobe_q, io_strobe_d;
   logic [15:0]   wr_count_q,  wr_count_d;
   logic [DW-1:0] mem_q [DEPTH];

   logic w_beat;
   logic w_cpu_wr;
   logic w_io_hit;

   assign w_beat   = ld_valid && (state_q == S_LOAD);
   assign w_io_hit = (address == IO_ADDR);
   assign w_cpu_wr = (state_q == S_RUN) && ce && we;

   always_comb begin
      state_d     = state_q;
      ld_words_d  = ld_words_q;
      io_out_d    = io_out_q;
      io_strobe_d = w_cpu_wr && w_io_hit;
      wr_count_d  = wr_count_q;
      if (w_beat) begin
         ld_words_d = ld_words_q + 1'b1;
         // Either an explicit last beat or filling the top word ends the load.
         if (ld_last || (ld_words_q == C_LAST_WORD)) begin
            state_d = S_RUN;
         end
      end
      if (w_cpu_wr) begin
         if (w_io_hit) begin
            io_out_d = dataW;
         end
         if (wr_count_q != 16'hFFFF) begin
            wr_count_d = wr_count_q + 16'd1;
         end
      end
   end

   always_ff @(posedge ck or posedge rst) begin
      if (rst) begin
         state_q     <= S_LOAD;
         ld_words_q  <= '0;
         cpu_rst_q   <= 1'b1;
         io_out_q    <= '0;
         io_strobe_q <= 1'b0;
         wr_count_q  <= '0;
      end else begin
         state_q     <= state_d;
         ld_words_q  <= ld_words_d;
         cpu_rst_q   <= (state_q != S_RUN);
         io_out_q    <= io_out_d;
         io_strobe_q <= io_strobe_d;
         wr_count_q  <= wr_count_d;
      end
   end

   // RAM is deliberately not reset so a partial image survives a reset.
   always_ff @(posedge ck) begin
      if (!rst) begin
         if (w_beat) begin
            mem_q[ld_words_q[AW-1:0]] <= ld_data;
         end else if (w_cpu_wr && !w_io_hit) begin
            mem_q[address] <= dataW;
         end
      end
   end

   always_comb begin
      dataR = '0;
      if ((state_q == S_RUN) && ce) begin
         dataR = w_io_hit ? io_out_q : mem_q[address];
      end
   end

   assign ld_ready  = (state_q == S_LOAD);
   assign ld_words  = ld_words_q;
   assign cpu_rst   = cpu_rst_q;
   assign io_out    = io_out_q;
   assign io_strobe = io_strobe_q;
   assign wr_count  = wr_count_q;

endmodule

`default_nettype wire
